// File: rtl/data_ram_pkg.sv
// rtl/data_ram_pkg.sv - shared state type and word helpers for the data RAM controller
package data_ram_pkg;

    typedef enum logic {INIT = 1'b0, READY = 1'b1} ram_state_t;

    // Helpers work on a fixed wide word; callers zero-extend and truncate.
    localparam int MAX_W = 128;
    localparam int MAX_B = MAX_W / 8;

    function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                    input logic [MAX_W-1:0] wdata,
                                                    input logic [MAX_B-1:0] wstrb);
        logic [MAX_W-1:0] merged;
        merged = old_w;
        for (int i = 0; i < MAX_B; i++) begin
            if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

    function automatic logic parity_of(input logic [MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/data_ram_if.sv
// rtl/data_ram_if.sv - request/response bus of the data RAM; DATA_RAM_PARITY_EN adds rsp_perr/inj_perr
interface data_ram_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W/8-1:0] req_wstrb;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              init_done;
`ifdef DATA_RAM_PARITY_EN
    logic              rsp_perr;
    logic              inj_perr;
`endif

    modport master (
`ifdef DATA_RAM_PARITY_EN
        output inj_perr,
        input  rsp_perr,
`endif
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, init_done
    );

    modport slave (
`ifdef DATA_RAM_PARITY_EN
        input  inj_perr,
        output rsp_perr,
`endif
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, init_done
    );
endinterface

// File: rtl/ram_array_sp.sv
// rtl/ram_array_sp.sv - single-port storage array, byte-enabled write, registered read
module ram_array_sp
    import data_ram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wbe,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= DATA_W'(byte_merge(MAX_W'(mem[addr]), MAX_W'(wdata), MAX_B'(wbe)));
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - data RAM controller: clear sweep FSM, valid/ready handshake, 1-cycle reads
// Optional word parity with error injection when DATA_RAM_PARITY_EN is defined.
module data_ram_ctrl
    import data_ram_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic      clk,
    input  logic      rst,
    data_ram_if.slave bus
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NB     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_oor_q, rsp_oor_d;

    logic              accept, in_range, rsp_valid;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
    logic [NB-1:0]     ram_wbe;

    // rst is folded in combinationally so nothing commits or shows while it is held.
    assign accept   = bus.req_valid && ready_q && !rst;
    assign in_range = 32'(bus.req_addr) < 32'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? INIT : READY;
            clr_cnt_q   <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_oor_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_oor_q   <= rsp_oor_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == INIT) begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == LAST_ADDR) begin
                state_d   = READY;
                clr_cnt_d = '0;
            end
        end
        ready_d     = (state_d == READY);
        rsp_valid_d = accept && !bus.req_write;
        rsp_oor_d   = accept && !bus.req_write && !in_range;
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = bus.req_addr;
        ram_wdata = bus.req_wdata;
        ram_wbe   = bus.req_wstrb;
        if (state_q == INIT) begin
            ram_we    = !rst;
            ram_addr  = clr_cnt_q;
            ram_wdata = '0;
            ram_wbe   = '1;
        end else begin
            ram_we = accept && bus.req_write && in_range && (|bus.req_wstrb);
            ram_re = accept && !bus.req_write && in_range;
        end
    end

    assign rsp_valid     = rsp_valid_q && !rst;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = (rsp_valid && !rsp_oor_q) ? ram_rdata : '0;
    assign bus.req_ready = ready_q && !rst;
    assign bus.init_done = ready_q && !rst;

    ram_array_sp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .wbe   (ram_wbe),
        .rdata (ram_rdata)
    );

`ifdef DATA_RAM_PARITY_EN
    // Per-byte parities plus an inject flag; their XOR is the word's stored even parity,
    // so partial writes keep it exact without reading the old word.
    logic [NB:0] par_mem [DEPTH];
    logic [NB:0] par_wdata, par_wbe, par_rdata_q;

    always_comb begin
        par_wdata = '0;
        for (int i = 0; i < NB; i++) par_wdata[i] = parity_of(MAX_W'(ram_wdata[8*i +: 8]));
        par_wdata[NB] = (state_q == READY) && bus.inj_perr;
        par_wbe = {|ram_wbe, ram_wbe};
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i <= NB; i++) begin
                if (par_wbe[i]) par_mem[ram_addr][i] <= par_wdata[i];
            end
        end
        if (ram_re) par_rdata_q <= par_mem[ram_addr];
    end

    assign bus.rsp_perr = rsp_valid && !rsp_oor_q &&
                          (parity_of(MAX_W'(par_rdata_q)) != parity_of(MAX_W'(ram_rdata)));
`endif

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - directed, table-driven bench for data_ram_ctrl (256 words cleared, 200 words retained)
module tb_data_ram_ctrl;

    logic clk = 1'b0;
    logic rst, rst2;
    always #5 clk = ~clk;

    data_ram_if #(.DATA_W(16), .ADDR_W(8)) bus ();
    data_ram_if #(.DATA_W(16), .ADDR_W(8)) bus2 ();

    data_ram_ctrl #(.DATA_W(16), .DEPTH(256), .CLEAR_ON_RESET(1)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    data_ram_ctrl #(.DATA_W(16), .DEPTH(200), .CLEAR_ON_RESET(0)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [1:0]  wstrb;
        logic        exp_v;
        logic [15:0] exp_d;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 2000) begin
            tick();
            n++;
        end
        check("wait_ready", bus.req_ready, 1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] s);
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr = a; bus.req_wdata = d; bus.req_wstrb = s;
        wait_ready();
        tick();
        bus.req_valid = 1'b0; bus.req_write = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [7:0] a, input logic [15:0] exp);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a;
        wait_ready();
        tick();
        bus.req_valid = 1'b0;
        check({name, "_valid"}, bus.rsp_valid, 1);
        check(name, bus.rsp_rdata, exp);
        tick();
        check({name, "_pulse"}, bus.rsp_valid, 0);
    endtask

    task automatic count_sweep(input string name);
        int cnt = 0;
        while (!bus.req_ready && cnt < 1000) begin
            cnt++;
            tick();
        end
        check(name, cnt, 256);
        check({name, "_init_done"}, bus.init_done, 1);
    endtask

    task automatic op2(input logic wr, input logic [7:0] a, input logic [15:0] d);
        bus2.req_valid = 1'b1; bus2.req_write = wr;
        bus2.req_addr = a; bus2.req_wdata = d; bus2.req_wstrb = 2'b11;
        tick();
        bus2.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_wstrb = 0;
        bus2.req_valid = 0; bus2.req_write = 0; bus2.req_addr = 0; bus2.req_wdata = 0; bus2.req_wstrb = 0;
`ifdef DATA_RAM_PARITY_EN
        bus.inj_perr = 0; bus2.inj_perr = 0;
`endif
        rst = 1'b1; rst2 = 1'b1;
        tick();
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_init_done", bus.init_done, 0);
        check("rst2_req_ready", bus2.req_ready, 0);
        rst = 1'b0; rst2 = 1'b0;
        tick();
        check("noclr_ready_first_edge", bus2.req_ready, 1);
        check("noclr_init_done", bus2.init_done, 1);

        // Preload nonzero, then reset and time the clear sweep.
        wait_ready();
        do_write(8'd0, 16'h1111, 2'b11);
        do_write(8'd128, 16'h2222, 2'b11);
        do_write(8'd255, 16'h3333, 2'b11);
        do_read("preload_128", 8'd128, 16'h2222);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_sweep("sweep_len");
        do_read("clr_0", 8'd0, 16'h0000);
        do_read("clr_128", 8'd128, 16'h0000);
        do_read("clr_255", 8'd255, 16'h0000);

        do_write(8'd5, 16'hBEEF, 2'b11);
        do_write(8'd5, 16'h1234, 2'b10);
        do_read("strobe_merge", 8'd5, 16'h12EF);

        // Write, then two reads on consecutive cycles.
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'd7;
        bus.req_wdata = 16'hA5A5; bus.req_wstrb = 2'b11;
        tick();
        bus.req_write = 1'b0;
        check("b2b_write_no_rsp", bus.rsp_valid, 0);
        tick();
        check("raw_valid", bus.rsp_valid, 1);
        check("raw_data", bus.rsp_rdata, 16'hA5A5);
        bus.req_addr = 8'd8;
        tick();
        check("b2b_valid", bus.rsp_valid, 1);
        check("b2b_data", bus.rsp_rdata, 16'h0000);
        bus.req_valid = 1'b0;
        tick();
        check("idle_valid", bus.rsp_valid, 0);
        check("idle_data", bus.rsp_rdata, 0);

        vecs[0]  = '{1'b1, 8'd20,  16'h1111, 2'b11, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 8'd20,  16'h0000, 2'b00, 1'b1, 16'h1111};
        vecs[2]  = '{1'b1, 8'd20,  16'hABCD, 2'b01, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 8'd20,  16'h0000, 2'b00, 1'b1, 16'h11CD};
        vecs[4]  = '{1'b1, 8'd20,  16'hFFFF, 2'b00, 1'b0, 16'h0000};
        vecs[5]  = '{1'b0, 8'd20,  16'h0000, 2'b00, 1'b1, 16'h11CD};
        vecs[6]  = '{1'b1, 8'd255, 16'h8001, 2'b11, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 8'd255, 16'h0000, 2'b00, 1'b1, 16'h8001};
        vecs[8]  = '{1'b0, 8'd0,   16'h0000, 2'b00, 1'b1, 16'h0000};
        vecs[9]  = '{1'b1, 8'd1,   16'h5A77, 2'b10, 1'b0, 16'h0000};
        vecs[10] = '{1'b0, 8'd1,   16'h0000, 2'b00, 1'b1, 16'h5A00};
        vecs[11] = '{1'b0, 8'd21,  16'h0000, 2'b00, 1'b1, 16'h0000};
        for (int i = 0; i < 12; i++) begin
            bus.req_valid = 1'b1; bus.req_write = vecs[i].wr; bus.req_addr = vecs[i].addr;
            bus.req_wdata = vecs[i].wdata; bus.req_wstrb = vecs[i].wstrb;
            tick();
            check($sformatf("vec%0d_valid", i), bus.rsp_valid, vecs[i].exp_v);
            check($sformatf("vec%0d_data", i), bus.rsp_rdata, vecs[i].exp_d);
        end
        bus.req_valid = 1'b0;
        tick();

        // Reset in the cycle after an accepted read drops the response.
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'd5;
        tick();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_supp_valid", bus.rsp_valid, 0);
        check("rst_supp_data", bus.rsp_rdata, 0);
        tick();
        rst = 1'b0;
        check("rst_supp_after", bus.rsp_valid, 0);
        count_sweep("sweep_restart");

        // Reset mid-sweep, with a read held the whole time.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'd9;
        begin
            int cnt = 0;
            logic early = 1'b0;
            while (!bus.req_ready && cnt < 1000) begin
                if (bus.rsp_valid) early = 1'b1;
                cnt++;
                tick();
            end
            check("midsweep_len", cnt, 256);
            check("held_read_no_early_rsp", early, 0);
        end
        tick();
        bus.req_valid = 1'b0;
        check("held_read_valid", bus.rsp_valid, 1);
        check("held_read_data", bus.rsp_rdata, 16'h0000);
        tick();

        // 200-word instance, contents kept over reset.
        op2(1'b1, 8'd10, 16'h7777);
        op2(1'b1, 8'd210, 16'h1234);
        op2(1'b0, 8'd210, 16'h0000);
        check("oor_read_valid", bus2.rsp_valid, 1);
        check("oor_read_data", bus2.rsp_rdata, 0);
        op2(1'b0, 8'd10, 16'h0000);
        check("alias_10_valid", bus2.rsp_valid, 1);
        check("alias_10_data", bus2.rsp_rdata, 16'h7777);
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        check("noclr_rst_ready", bus2.req_ready, 0);
        tick();
        check("noclr_ready_again", bus2.req_ready, 1);
        op2(1'b0, 8'd10, 16'h0000);
        check("retained_10", bus2.rsp_rdata, 16'h7777);
`ifdef DATA_RAM_PARITY_EN
        op2(1'b0, 8'd210, 16'h0000);
        check("oor_perr", bus2.rsp_perr, 0);

        bus.inj_perr = 1'b1;
        do_write(8'd30, 16'h0F0F, 2'b11);
        bus.inj_perr = 1'b0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'd30;
        tick();
        bus.req_valid = 1'b0;
        check("inj_perr_data", bus.rsp_rdata, 16'h0F0F);
        check("inj_perr_flag", bus.rsp_perr, 1);
        tick();
        do_write(8'd30, 16'h0F0F, 2'b11);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'd30;
        tick();
        bus.req_valid = 1'b0;
        check("clean_perr_flag", bus.rsp_perr, 0);
        tick();
        do_write(8'd31, 16'h0103, 2'b01);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'd31;
        tick();
        bus.req_valid = 1'b0;
        check("partial_perr_flag", bus.rsp_perr, 0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
